// File: rtl/key_sw_debounce_pkg.sv
// Shared constants for the key/switch conditioning stage: register bit layout,
// input counts, reset levels and the debounce counter width helper.
package key_sw_debounce_pkg;

    localparam int SW_LO_LSB = 0;
    localparam int KEY_LSB   = 9;
    localparam int PRESS_LSB = 12;
    localparam int MASK_LSB  = 15;
    localparam int SW_HI_LSB = 22;

    localparam int NUM_KEYS = 3;
    localparam int NUM_SW   = 18;
    localparam int SW_LO_W  = 8;
    localparam int SW_HI_W  = NUM_SW - SW_LO_W;

    // Inputs reset to "released / off" in active-high terms.
    localparam logic SYNC_RST   = 1'b0;
    localparam logic STABLE_RST = 1'b0;

    // A single-cycle debounce still needs a one-bit counter to be legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_sw_debounce_debounce_cell.sv
// One input: two-flop synchronizer, debounce counter and stable level, plus a
// one-cycle rise strobe registered on the edge the stable level goes 0->1.
module debounce_cell
    import key_sw_debounce_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int             CW      = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= SYNC_RST;
            s2    <= SYNC_RST;
            level <= STABLE_RST;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            rise <= 1'b0;
            // Any return to the stable value restarts the qualification window.
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= s2;
                cnt   <= '0;
                rise  <= s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_sw_debounce.sv
// Debounces KEY3..KEY1 and SW17..SW0, keeps sticky key-press flags and exposes a
// word-wide register port. Optional KEY_DEBOUNCE_IRQ_EN adds an irq mask and irq.
module key_sw_debounce
    import key_sw_debounce_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_SW-1:0]   sw,
    output logic [NUM_KEYS-1:0] key_db,
    output logic [NUM_SW-1:0]   sw_db,
    input  logic                en,
    input  logic                wr,
    input  logic [31:0]         data_in,
    output logic [31:0]         data_out
`ifdef KEY_DEBOUNCE_IRQ_EN
    ,
    output logic                irq
`endif
);

    logic [NUM_KEYS-1:0] key_rise;
    logic [NUM_SW-1:0]   sw_rise_unused;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] clr;
    logic                wr_en;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .din   (~key_n[i]),
            .level (key_db[i]),
            .rise  (key_rise[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .din   (sw[i]),
            .level (sw_db[i]),
            .rise  (sw_rise_unused[i])
        );
    end

    assign wr_en = en & wr;
    assign clr   = wr_en ? data_in[PRESS_LSB +: NUM_KEYS] : '0;

    // A rise arriving on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press <= '0;
        end else begin
            press <= (press & ~clr) | key_rise;
        end
    end

`ifdef KEY_DEBOUNCE_IRQ_EN
    logic [NUM_KEYS-1:0] irq_mask;
    logic                unused_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_mask <= '0;
        end else if (wr_en) begin
            irq_mask <= data_in[MASK_LSB +: NUM_KEYS];
        end
    end

    assign irq        = |(press & irq_mask);
    assign unused_din = ^{data_in[31:MASK_LSB+NUM_KEYS], data_in[PRESS_LSB-1:0]};
`else
    logic unused_din;
    assign unused_din = ^{data_in[31:PRESS_LSB+NUM_KEYS], data_in[PRESS_LSB-1:0]};
`endif

    always_comb begin
        data_out                          = '0;
        data_out[SW_LO_LSB +: SW_LO_W]    = sw_db[SW_LO_W-1:0];
        data_out[KEY_LSB +: NUM_KEYS]     = key_db;
        data_out[PRESS_LSB +: NUM_KEYS]   = press;
`ifdef KEY_DEBOUNCE_IRQ_EN
        data_out[MASK_LSB +: NUM_KEYS]    = irq_mask;
`endif
        data_out[SW_HI_LSB +: SW_HI_W]    = sw_db[NUM_SW-1:SW_LO_W];
    end

endmodule

// File: tb/tb_key_sw_debounce.sv
// Bench for key_sw_debounce with DB_CYCLES=4: directed timing scenarios plus
// randomized activity checked against a sliding-window reference model.
module tb_key_sw_debounce;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  key_n = 3'b111;
    logic [17:0] sw = '0;
    logic [2:0]  key_db;
    logic [17:0] sw_db;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
`ifdef KEY_DEBOUNCE_IRQ_EN
    logic        irq;
`endif

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    key_sw_debounce #(.DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_n    (key_n),
        .sw       (sw),
        .key_db   (key_db),
        .sw_db    (sw_db),
        .en       (en),
        .wr       (wr),
        .data_in  (data_in),
        .data_out (data_out)
`ifdef KEY_DEBOUNCE_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    // Reference model: bit order {sw[17:0], key[2:0]} in active-high terms.
    // A level flips once the raw samples taken 2..DB+1 edges back all disagree with it.
    logic [20:0] hist [0:7];
    logic [20:0] m_level;
    logic [2:0]  m_rise;
    logic [2:0]  m_press;
    logic [2:0]  m_mask;

    function automatic logic [20:0] next_level();
        logic [20:0] res;
        for (int b = 0; b < 21; b++) begin
            logic flip;
            flip = 1'b1;
            for (int j = 1; j <= DB; j++)
                if (hist[j][b] == m_level[b]) flip = 1'b0;
            res[b] = flip ? ~m_level[b] : m_level[b];
        end
        return res;
    endfunction

    function automatic logic [31:0] exp_dout();
        logic [31:0] d;
        d        = '0;
        d[7:0]   = m_level[10:3];
        d[11:9]  = m_level[2:0];
        d[14:12] = m_press;
`ifdef KEY_DEBOUNCE_IRQ_EN
        d[17:15] = m_mask;
`endif
        d[31:22] = m_level[20:11];
        return d;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 8; j++) hist[j] <= '0;
            m_level <= '0;
            m_rise  <= '0;
            m_press <= '0;
            m_mask  <= '0;
        end else begin
            logic [20:0] nl;
            logic [2:0]  c;
            nl = next_level();
            c  = (en && wr) ? data_in[14:12] : 3'b000;
            m_rise  <= nl[2:0] & ~m_level[2:0];
            m_level <= nl;
            m_press <= (m_press & ~c) | m_rise;
            if (en && wr) m_mask <= data_in[17:15];
            hist[0] <= {sw, ~key_n};
            for (int j = 1; j < 8; j++) hist[j] <= hist[j-1];
        end
    end

    task automatic write_reg(input logic [31:0] d);
        en = 1'b1; wr = 1'b1; data_in = d;
        @(negedge clk);
        en = 1'b0; wr = 1'b0; data_in = '0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (data_out !== 32'h0) $display("FAIL reset_dout: got %h expected %h", data_out, 32'h0);
        else pass_cnt++;
        total++;
        if ({key_db, sw_db} !== 21'h0) $display("FAIL reset_levels: got %h expected 0", {key_db, sw_db});
        else pass_cnt++;
    endtask

    task automatic test_key_press();
        key_n[0] = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            @(negedge clk);
            total++;
            if (key_db[0] !== (e >= 5)) $display("FAIL key_db0_e%0d: got %b expected %b", e, key_db[0], (e >= 5));
            else pass_cnt++;
            if (e >= 5) begin
                total++;
                if ({data_out[12], data_out[9]} !== {(e >= 6), 1'b1})
                    $display("FAIL press0_e%0d: got %b expected %b", e, {data_out[12], data_out[9]}, {(e >= 6), 1'b1});
                else pass_cnt++;
            end
        end
        key_n[0] = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (data_out[14:9] !== 6'b001_000) $display("FAIL press0_sticky: got %b expected 001000", data_out[14:9]);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 10; r++) begin
            int len;
            len = (r < 5) ? 3 : $urandom_range(1, 3);
            key_n[1] = 1'b0;
            repeat (len) @(negedge clk);
            key_n[1] = 1'b1;
            repeat (4) @(negedge clk);
            total++;
            if ({key_db[1], data_out[13], data_out[10]} !== 3'b000)
                $display("FAIL glitch_r%0d: got %b expected 000", r, {key_db[1], data_out[13], data_out[10]});
            else pass_cnt++;
        end
    endtask

    task automatic test_clear();
        key_n[1] = 1'b0;
        repeat (8) @(negedge clk);
        key_n[1] = 1'b1;
        repeat (8) @(negedge clk);
        write_reg(32'h0000_1000);
        total++;
        if (data_out[14:12] !== 3'b010) $display("FAIL clear0: got %b expected 010", data_out[14:12]);
        else pass_cnt++;
        // New press of KEY1 whose flag sets on the same edge as a clear.
        key_n[0] = 1'b0;
        repeat (6) @(negedge clk);
        write_reg(32'h0000_1000);
        total++;
        if (data_out[14:12] !== 3'b011) $display("FAIL set_wins: got %b expected 011", data_out[14:12]);
        else pass_cnt++;
        key_n[0] = 1'b1;
        repeat (8) @(negedge clk);
        write_reg(32'h0000_7000);
        total++;
        if (data_out !== 32'h0) $display("FAIL clear_all: got %h expected 0", data_out);
        else pass_cnt++;
    endtask

    task automatic test_switches();
        sw = 18'h3FFFF;
        for (int e = 0; e <= 6; e++) begin
            @(negedge clk);
            if (e >= 4) begin
                total++;
                if (data_out !== ((e >= 5) ? 32'hFFC0_00FF : 32'h0))
                    $display("FAIL sw_on_e%0d: got %h expected %h", e, data_out, (e >= 5) ? 32'hFFC0_00FF : 32'h0);
                else pass_cnt++;
            end
        end
        sw = '0;
        for (int e = 0; e <= 5; e++) begin
            @(negedge clk);
            if (e >= 4) begin
                total++;
                if (data_out !== ((e >= 5) ? 32'h0 : 32'hFFC0_00FF))
                    $display("FAIL sw_off_e%0d: got %h expected %h", e, data_out, (e >= 5) ? 32'h0 : 32'hFFC0_00FF);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        sw = 18'h00155;
        repeat (8) @(negedge clk);
        key_n[2] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({data_out, key_db, sw_db} !== 53'h0)
            $display("FAIL rst_async: got %h %b %h expected all 0", data_out, key_db, sw_db);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            @(negedge clk);
            total++;
            if ({key_db[2], sw_db} !== {(e >= 5), (e >= 5) ? 18'h00155 : 18'h0})
                $display("FAIL rst_redb_e%0d: got %b %h", e, key_db[2], sw_db);
            else pass_cnt++;
        end
        total++;
        if (data_out[14:12] !== 3'b100) $display("FAIL rst_press2: got %b expected 100", data_out[14:12]);
        else pass_cnt++;
        key_n[2] = 1'b1;
        sw = '0;
        repeat (8) @(negedge clk);
        write_reg(32'h0000_7000);
    endtask

`ifdef KEY_DEBOUNCE_IRQ_EN
    task automatic test_irq();
        write_reg(32'h0000_8000);
        key_n[0] = 1'b0;
        repeat (7) @(negedge clk);
        total++;
        if ({irq, data_out[12]} !== 2'b11) $display("FAIL irq_set: got %b expected 11", {irq, data_out[12]});
        else pass_cnt++;
        key_n[0] = 1'b1;
        write_reg(32'h0000_9000);
        total++;
        if ({irq, data_out[17:15]} !== 4'b0001) $display("FAIL irq_clr: got %b expected 0001", {irq, data_out[17:15]});
        else pass_cnt++;
        key_n[1] = 1'b0;
        repeat (7) @(negedge clk);
        total++;
        if ({irq, data_out[13]} !== 2'b01) $display("FAIL irq_masked: got %b expected 01", {irq, data_out[13]});
        else pass_cnt++;
        key_n[1] = 1'b1;
        repeat (8) @(negedge clk);
    endtask
`endif

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) key_n = 3'($urandom);
            if ($urandom_range(0, 7) == 0) sw = sw ^ 18'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                en = 1'b1; wr = ($urandom_range(0, 1) == 1); data_in = $urandom;
            end else begin
                en = ($urandom_range(0, 3) == 0); wr = 1'b0; data_in = $urandom;
            end
            @(negedge clk);
            total++;
            if ({data_out, key_db, sw_db} !== {exp_dout(), m_level[2:0], m_level[20:3]}) begin
                if (bad < 10)
                    $display("FAIL rand_c%0d: got %h/%b/%h expected %h/%b/%h", c, data_out, key_db, sw_db,
                             exp_dout(), m_level[2:0], m_level[20:3]);
                bad++;
            end else pass_cnt++;
`ifdef KEY_DEBOUNCE_IRQ_EN
            total++;
            if (irq !== |(m_press & m_mask)) $display("FAIL rand_irq_c%0d: got %b expected %b", c, irq, |(m_press & m_mask));
            else pass_cnt++;
`endif
        end
        en = 1'b0; wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_key_press();
        test_glitch();
        test_clear();
        test_switches();
        test_reset_mid();
`ifdef KEY_DEBOUNCE_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
